// File: rtl/streaming_sha256.sv
`default_nettype none
// ============================================================================
//  Module   : streaming_sha256
//  Brief    : Streaming SHA-256 engine. Accepts big-endian message words,
//             applies padding and the 64-bit length, compresses each 512-bit
//             block at one round per cycle, and strobes the final digest.
//  Revision : 1.0  initial release
// ============================================================================
module streaming_sha256 (
    input  logic         clk,
    input  logic         rst,
    input  logic         start,
    input  logic         update,
    input  logic [31:0]  data_in,
    input  logic [2:0]   bytes_valid,
    input  logic         finalize,
    output logic         hash_valid,
    output logic [255:0] hash
);
    // Message-side states: accepting data, then the padding sequence, then done.
    localparam logic [2:0] c_st_open   = 3'd0;
    localparam logic [2:0] c_st_pad80  = 3'd1;
    localparam logic [2:0] c_st_zero   = 3'd2;
    localparam logic [2:0] c_st_len_hi = 3'd3;
    localparam logic [2:0] c_st_len_lo = 3'd4;
    localparam logic [2:0] c_st_wait   = 3'd5;
    localparam logic [2:0] c_st_closed = 3'd6;

    localparam logic [0:7][31:0] c_iv = {
        32'h6a09e667, 32'hbb67ae85, 32'h3c6ef372, 32'ha54ff53a,
        32'h510e527f, 32'h9b05688c, 32'h1f83d9ab, 32'h5be0cd19};

    localparam logic [0:63][31:0] c_k = {
        32'h428a2f98, 32'h71374491, 32'hb5c0fbcf, 32'he9b5dba5, 32'h3956c25b, 32'h59f111f1, 32'h923f82a4, 32'hab1c5ed5,
        32'hd807aa98, 32'h12835b01, 32'h243185be, 32'h550c7dc3, 32'h72be5d74, 32'h80deb1fe, 32'h9bdc06a7, 32'hc19bf174,
        32'he49b69c1, 32'hefbe4786, 32'h0fc19dc6, 32'h240ca1cc, 32'h2de92c6f, 32'h4a7484aa, 32'h5cb0a9dc, 32'h76f988da,
        32'h983e5152, 32'ha831c66d, 32'hb00327c8, 32'hbf597fc7, 32'hc6e00bf3, 32'hd5a79147, 32'h06ca6351, 32'h14292967,
        32'h27b70a85, 32'h2e1b2138, 32'h4d2c6dfc, 32'h53380d13, 32'h650a7354, 32'h766a0abb, 32'h81c2c92e, 32'h92722c85,
        32'ha2bfe8a1, 32'ha81a664b, 32'hc24b8b70, 32'hc76c51a3, 32'hd192e819, 32'hd6990624, 32'hf40e3585, 32'h106aa070,
        32'h19a4c116, 32'h1e376c08, 32'h2748774c, 32'h34b0bcb5, 32'h391c0cb3, 32'h4ed8aa4a, 32'h5b9cca4f, 32'h682e6ff3,
        32'h748f82ee, 32'h78a5636f, 32'h84c87814, 32'h8cc70208, 32'h90befffa, 32'ha4506ceb, 32'hbef9a3f7, 32'hc67178f2};

    function automatic logic [31:0] ror(input logic [31:0] x, input int n);
        return (x >> n) | (x << (32 - n));
    endfunction

    logic [2:0]  r_state, w_next;
    logic [31:0] r_buf [0:15];   // input buffer being filled
    logic [4:0]  r_wptr;         // 16 means full and waiting for the compressor
    logic [31:0] r_win [0:15];   // sliding message-schedule window
    logic [31:0] r_wv  [0:7];    // working variables a..h
    logic [31:0] r_hs  [0:7];    // chaining state H0..H7
    logic        r_busy, r_add;
    logic [5:0]  r_round;
    logic [31:0] r_count;        // message byte count

    logic        w_dispatch, w_upd, w_fin, w_full_eff, w_pad_wr, w_wr, w_emit;
    logic [4:0]  w_ptr_eff;
    logic [31:0] w_pad_data, w_wdata, w_masked, w_t1, w_t2, w_wnew;

    // Buffer handoff and strobe qualification. A dispatch frees the buffer in
    // the same cycle, so an update arriving then lands in word 0.
    always_comb begin
        w_dispatch = (r_wptr == 5'd16) && !r_busy;
        w_ptr_eff  = w_dispatch ? 5'd0 : r_wptr;
        w_full_eff = (w_ptr_eff == 5'd16);
        w_upd      = update   && !start && (r_state == c_st_open);
        w_fin      = finalize && !start && (r_state == c_st_open);
        // A short word is always the last one, so its 0x80 pad byte goes in now.
        case (bytes_valid)
            3'd1:    w_masked = {data_in[31:24], 24'h800000};
            3'd2:    w_masked = {data_in[31:16], 16'h8000};
            3'd3:    w_masked = {data_in[31:8], 8'h80};
            default: w_masked = data_in;
        endcase
    end

    // Padding sequencer: next-state logic.
    always_comb begin
        w_next = r_state;
        case (r_state)
            c_st_open:   if (w_fin) w_next = (r_count[1:0] == 2'd0) ? c_st_pad80 : c_st_zero;
            c_st_pad80:  if (!w_full_eff) w_next = c_st_zero;
            c_st_zero:   if (!w_full_eff && w_ptr_eff == 5'd14) w_next = c_st_len_hi;
            c_st_len_hi: if (!w_full_eff) w_next = c_st_len_lo;
            c_st_len_lo: if (!w_full_eff) w_next = c_st_wait;
            c_st_wait:   if (w_emit) w_next = c_st_closed;
            default:     w_next = r_state;
        endcase
    end

    // Padding sequencer: buffer writes and digest release.
    always_comb begin
        w_pad_wr   = 1'b0;
        w_pad_data = 32'd0;
        case (r_state)
            c_st_pad80:  begin w_pad_wr = !w_full_eff; w_pad_data = 32'h80000000; end
            c_st_zero:   w_pad_wr = !w_full_eff && (w_ptr_eff != 5'd14);
            c_st_len_hi: begin w_pad_wr = !w_full_eff; w_pad_data = {29'd0, r_count[31:29]}; end
            c_st_len_lo: begin w_pad_wr = !w_full_eff; w_pad_data = {r_count[28:0], 3'd0}; end
            default:     w_pad_wr = 1'b0;
        endcase
        w_wr    = w_upd || w_pad_wr;
        w_wdata = w_upd ? w_masked : w_pad_data;
        // Last block is done once the buffer is drained and the compressor idle.
        w_emit  = (r_state == c_st_wait) && !r_busy && (r_wptr == 5'd0);
    end

    // One compression round plus the next schedule word.
    always_comb begin
        w_t1 = r_wv[7] + (ror(r_wv[4], 6) ^ ror(r_wv[4], 11) ^ ror(r_wv[4], 25))
             + ((r_wv[4] & r_wv[5]) ^ (~r_wv[4] & r_wv[6])) + c_k[r_round] + r_win[0];
        w_t2 = (ror(r_wv[0], 2) ^ ror(r_wv[0], 13) ^ ror(r_wv[0], 22))
             + ((r_wv[0] & r_wv[1]) ^ (r_wv[0] & r_wv[2]) ^ (r_wv[1] & r_wv[2]));
        w_wnew = (ror(r_win[14], 17) ^ ror(r_win[14], 19) ^ (r_win[14] >> 10)) + r_win[9]
               + (ror(r_win[1], 7) ^ ror(r_win[1], 18) ^ (r_win[1] >> 3)) + r_win[0];
    end

    // Sequencer state register; start reopens the message.
    always_ff @(posedge clk) begin
        if (rst || start) r_state <= c_st_open;
        else              r_state <= w_next;
    end

    // Buffer, compressor, chaining state and digest output.
    always_ff @(posedge clk) begin
        if (rst || start) begin
            for (int i = 0; i < 8; i++) r_hs[i] <= c_iv[i];
            r_wptr     <= 5'd0;
            r_busy     <= 1'b0;
            r_add      <= 1'b0;
            r_round    <= 6'd0;
            r_count    <= 32'd0;
            hash_valid <= 1'b0;
            if (rst) begin
                hash <= 256'd0;
                for (int i = 0; i < 16; i++) begin
                    r_buf[i] <= 32'd0;
                    r_win[i] <= 32'd0;
                end
                for (int i = 0; i < 8; i++) r_wv[i] <= 32'd0;
            end
        end else begin
            hash_valid <= 1'b0;
            if (w_wr) begin
                r_buf[w_ptr_eff[3:0]] <= w_wdata;
                r_wptr <= w_ptr_eff + 5'd1;
            end else if (w_dispatch) begin
                r_wptr <= 5'd0;
            end
            if (w_upd) r_count <= r_count + {29'd0, bytes_valid};
            if (w_dispatch) begin
                r_win   <= r_buf;
                r_wv    <= r_hs;
                r_busy  <= 1'b1;
                r_add   <= 1'b0;
                r_round <= 6'd0;
            end else if (r_busy) begin
                if (r_add) begin
                    for (int i = 0; i < 8; i++) r_hs[i] <= r_hs[i] + r_wv[i];
                    r_busy <= 1'b0;
                    r_add  <= 1'b0;
                end else begin
                    r_wv[0] <= w_t1 + w_t2;
                    r_wv[1] <= r_wv[0];
                    r_wv[2] <= r_wv[1];
                    r_wv[3] <= r_wv[2];
                    r_wv[4] <= r_wv[3] + w_t1;
                    r_wv[5] <= r_wv[4];
                    r_wv[6] <= r_wv[5];
                    r_wv[7] <= r_wv[6];
                    for (int i = 0; i < 15; i++) r_win[i] <= r_win[i + 1];
                    r_win[15] <= w_wnew;
                    r_round   <= r_round + 6'd1;
                    if (r_round == 6'd63) r_add <= 1'b1;
                end
            end
            if (w_emit) begin
                hash <= {r_hs[0], r_hs[1], r_hs[2], r_hs[3], r_hs[4], r_hs[5], r_hs[6], r_hs[7]};
                hash_valid <= 1'b1;
            end
        end
    end
endmodule
`default_nettype wire

// File: tb/tb_streaming_sha256.sv
`default_nettype none
// ============================================================================
//  Module   : tb_streaming_sha256
//  Brief    : Directed vector bench for streaming_sha256 (known digests).
//  Revision : 1.0  initial release
// ============================================================================
module tb_streaming_sha256;
    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic         start = 1'b0;
    logic         update = 1'b0;
    logic [31:0]  data_in = 32'd0;
    logic [2:0]   bytes_valid = 3'd0;
    logic         finalize = 1'b0;
    logic         hash_valid;
    logic [255:0] hash;

    int checks = 0;
    int errors = 0;

    localparam logic [255:0] c_dig_a =
        256'hca978112ca1bbdcafac231b39a23dc4da786eff8147c4e72b9807785afee48bb;

    typedef struct {
        logic [7:0]   ch;
        int           len;
        int           gap_word;
        int           gap_cyc;
        logic [255:0] exp;
    } vec_t;

    vec_t vecs [8];

    streaming_sha256 dut (
        .clk         (clk),
        .rst         (rst),
        .start       (start),
        .update      (update),
        .data_in     (data_in),
        .bytes_valid (bytes_valid),
        .finalize    (finalize),
        .hash_valid  (hash_valid),
        .hash        (hash)
    );

    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic check256(input string name, input logic [255:0] act, input logic [255:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic check_int(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic pulse_start();
        @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
    endtask

    // Push len bytes of ch (optionally idling gap_cyc cycles before word
    // gap_word), then finalize on the cycle after the last update.
    task automatic send_msg(input logic [7:0] ch, input int len, input int gap_word, input int gap_cyc);
        int nwords;
        nwords = (len + 3) / 4;
        for (int i = 0; i < nwords; i++) begin
            @(negedge clk);
            if (i == gap_word && gap_cyc > 0) begin
                update = 1'b0;
                repeat (gap_cyc) @(negedge clk);
            end
            data_in = 32'd0;
            for (int j = 0; j < 4; j++)
                if (4 * i + j < len) data_in[31 - 8 * j -: 8] = ch;
            bytes_valid = (len - 4 * i >= 4) ? 3'd4 : 3'(len - 4 * i);
            update = 1'b1;
        end
        @(negedge clk);
        update      = 1'b0;
        data_in     = 32'd0;
        bytes_valid = 3'd0;
        finalize    = 1'b1;
        @(negedge clk);
        finalize = 1'b0;
    endtask

    // Wait (bounded) for the digest strobe, compare it, then check the strobe
    // lasts exactly one cycle.
    task automatic wait_hash(input string name, input logic [255:0] exp);
        int n;
        n = 0;
        while (hash_valid !== 1'b1 && n < 400) begin
            @(negedge clk);
            n++;
        end
        if (hash_valid !== 1'b1) begin
            checks++;
            errors++;
            $display("FAIL %s: hash_valid never asserted within 400 cycles", name);
        end else begin
            check256(name, hash, exp);
            @(negedge clk);
            check_int({name, "_pulse_width"}, int'(hash_valid), 0);
        end
    endtask

    initial begin
        int pulses;
        vecs[0] = '{8'h61, 1,   -1, 0,  c_dig_a};
        vecs[1] = '{8'h41, 0,   -1, 0,  256'he3b0c44298fc1c149afbf4c8996fb92427ae41e4649b934ca495991b7852b855};
        vecs[2] = '{8'h41, 64,  -1, 0,  256'hd53eda7a637c99cc7fb566d96e9fa109bf15c478410a3f5eb4d4c4e26cd081f6};
        vecs[3] = '{8'h41, 65,  -1, 0,  256'h836203944f4c0280461ad73d31457c22ba19d1d99e232dc231000085899e00a2};
        vecs[4] = '{8'h41, 63,  -1, 0,  256'h1b58d00f5b1fbd2a1884d666a2be33c2fa7463dff32cd60ef200c0f750a6b70f};
        vecs[5] = '{8'h41, 71,  -1, 0,  256'h96b437b3df7c62fc877a121b087899f5e36a58f6d87ba52d997e92bb016aa575};
        vecs[6] = '{8'h41, 79,  -1, 0,  256'h1581baebc5f9dcfd89c658b3c3303203fc0e2f93e3f9e0b593d8b2b8112c6eda};
        vecs[7] = '{8'h41, 128, 14, 51, 256'hb6ac3cc10386331c765f04f041c147d0f278f2aed8eaa021e2d0057fc6f6ff9e};

        // Reset state
        repeat (3) @(negedge clk);
        rst = 1'b0;
        check256("reset_hash", hash, 256'd0);
        check_int("reset_hash_valid", int'(hash_valid), 0);

        // Table of known-answer messages
        for (int v = 0; v < 8; v++) begin
            pulse_start();
            send_msg(vecs[v].ch, vecs[v].len, vecs[v].gap_word, vecs[v].gap_cyc);
            wait_hash($sformatf("vec%0d_len%0d", v, vecs[v].len), vecs[v].exp);
        end

        // start holds the previous digest and clears the strobe
        pulse_start();
        check256("start_holds_hash", hash, vecs[7].exp);
        check_int("start_hash_valid", int'(hash_valid), 0);

        // Reset in the middle of compression, then hash "a" without start
        send_msg(8'h41, 64, -1, 0);
        repeat (20) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
        check256("midrst_hash", hash, 256'd0);
        check_int("midrst_hash_valid", int'(hash_valid), 0);
        send_msg(8'h61, 1, -1, 0);
        wait_hash("after_reset_a", c_dig_a);

        // Updates and finalize after finalize are ignored
        pulse_start();
        send_msg(8'h61, 1, -1, 0);
        @(negedge clk);
        update = 1'b1; data_in = 32'h62626262; bytes_valid = 3'd4; finalize = 1'b1;
        @(negedge clk);
        update = 1'b0; data_in = 32'd0; bytes_valid = 3'd0; finalize = 1'b0;
        wait_hash("ignore_after_fin", c_dig_a);
        pulses = 0;
        for (int i = 0; i < 250; i++) begin
            @(negedge clk);
            if (hash_valid === 1'b1) pulses++;
        end
        check_int("no_second_digest", pulses, 0);

        // start wins over an update in the same cycle
        @(negedge clk);
        start = 1'b1; update = 1'b1; data_in = 32'h62000000; bytes_valid = 3'd1;
        @(negedge clk);
        start = 1'b0; update = 1'b0; data_in = 32'd0; bytes_valid = 3'd0;
        send_msg(8'h61, 1, -1, 0);
        wait_hash("start_beats_update", c_dig_a);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
`default_nettype wire
